led7seg_scan: RTL and testbench
===============================

Name: led7seg_scan

Overview:
- Multi-digit time-multiplexed scan driver that sits directly upstream of the 7-segment decoder.
- Holds NUM_DIGITS packed BCD nibbles and walks through them at a prescaled refresh rate.
- Each step presents one nibble on inled_out, which drives the decoder's 4-bit input, and the matching active-low digit enable on an.
- New display values are double-buffered and committed only at a frame boundary, so a refresh never shows a mix of old and new digits (tear-free).

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- REFRESH_DIV, 50000, clk cycles per digit step; legal range >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- load  input  1  single-cycle strobe: capture digits_in.
- digits_in  input  4*NUM_DIGITS  packed nibbles; digit k = bits [4k+3:4k]; digit 0 = least significant/rightmost.
- inled_out  output  4  nibble of the currently enabled digit, to the decoder input.
- an  output  NUM_DIGITS  digit enables, active-low, at most one bit low.
- frame_done  output  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
Reset (rst_n low, takes effect asynchronously):
- prescaler = 0, idx = NUM_DIGITS-1.
- active and pending registers = 0, pending_valid = 0.
- an = all ones (all digits off), inled_out = 0, frame_done = 0.

Prescaler and step:
- Counts 0..REFRESH_DIV-1, then wraps.
- tick = (prescaler == REFRESH_DIV-1); with REFRESH_DIV=1, tick is asserted every cycle.

Step (on a tick):
- idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
- Registered outputs update on the same edge:
  - an <= ~(1 << new idx).
  - inled_out <= active digit[new idx], using the active value after any commit on that edge.
- Latency: outputs change exactly on the tick edge; no outputs change between ticks.
- Frame boundary = a tick on which the new idx is 0.
- The first tick after reset is a frame boundary.
- With NUM_DIGITS=1, every tick is a frame boundary.

Load:
- Non-boundary cycle: pending <= digits_in, pending_valid <= 1.
- Multiple loads in one frame: last one wins.

Commit (on a frame boundary):
- If pending_valid: active <= pending, pending_valid <= 0.
- frame_done = 1 for that cycle only.

Simultaneous load and frame boundary:
- digits_in is written directly to active; pending_valid <= 0.
- Digit 0 of this frame already shows the new value.

Data handling:
- Nibbles 10..15 pass through unchanged; decoding them is the downstream decoder's job.
- No arithmetic on digit data.

Reset mid-operation:
- All state returns to reset values immediately; an in-flight pending load is discarded.

Optional Feature:
Macro: LED7SEG_LEADING_ZERO_BLANK_EN
- Defined:
  - Any digit above the most significant nonzero digit of active keeps its an bit high (blanked) when selected.
  - idx still advances and inled_out still carries the nibble.
  - Digit 0 is never blanked, so an all-zero value shows "0".
  - Blanking is evaluated from active as committed on that tick.
- Undefined: every selected digit is enabled; no extra logic is generated.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4.
- Reset/first frame: hold rst_n=0 → an=4'b1111, inled_out=0, frame_done=0. Release, pulse load with 16'h1234 on cycle 1 → at the 4th edge after release: an=4'b1110, inled_out=4, frame_done=1 for one cycle.
- Scan order: continue → every 4 cycles an/inled_out = 1101/3, 1011/2, 0111/1, then 1110/4 with frame_done=1; no change between ticks.
- Tear-free update: load 16'h5678 while idx=1 → rest of the frame still shows 2 then 1; next frame shows 8,7,6,5. Two loads in one frame (16'hAAAA then 16'h0007) → next frame shows 7,0,0,0.
- Simultaneous load and boundary: load 16'h9999 in the cycle where frame_done=1 → inled_out=9 on that same edge, and the frame shows 9 on all digits.
- Async reset mid-scan: drop rst_n between clock edges while idx=2 with a pending load → outputs go to reset values without waiting for clk. After release, the first frame shows 0000, not the pending value.
- Macro defined: active=16'h0042 → digits 3 and 2 keep an=1 when selected, digits 1 and 0 show 4 and 2. active=16'h0000 → only digit 0 is enabled, inled_out=0.

Source files
------------

// File: rtl/led7seg_scan.sv
// led7seg_scan: time-multiplexed scan driver for a multi-digit 7-segment display.
// Holds NUM_DIGITS packed BCD nibbles. At a prescaled rate it steps through
// them, presenting one nibble on inled_out and the matching active-low digit
// enable on an. New values are double-buffered and committed only at a frame
// boundary, so no refresh ever mixes old and new digits.
//
// Optional build macro: LED7SEG_LEADING_ZERO_BLANK_EN
//   When defined, digits above the most significant nonzero digit keep their
//   enable high (blanked). Digit 0 is never blanked.

module led7seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              inled_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESCALE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_next;
  logic [DW-1:0]         active;
  logic [DW-1:0]         active_next;
  logic [DW-1:0]         pending;
  logic                  pending_valid;
  logic                  tick;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] an_next;

  // Step decode: tick, next digit index, frame boundary and the active value
  // as it will stand after any commit on this edge.
  // NOTE: every signal driven here gets a default first so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    tick        = (prescaler == PRESCALE_LAST);
    idx_next    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    boundary    = tick && (idx_next == '0);
    active_next = active;
    if (boundary) begin
      if (load) begin
        // A load landing on the boundary goes straight to the display, so
        // digit 0 of this frame already shows it.
        active_next = digits_in;
      end else if (pending_valid) begin
        active_next = pending;
      end
    end
  end

`ifdef LED7SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  leading;

  // Leading-zero mask: walk down from the top digit; every digit above the
  // first nonzero one is blanked. Digit 0 is never blanked.
  always_comb begin
    blank   = '0;
    leading = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (active_next[4*k +: 4] != 4'h0) leading = 1'b0;
      blank[k] = leading;
    end
  end

  // Enable for the next digit, forced high when that digit is a leading zero.
  always_comb begin
    an_next = ~(NUM_DIGITS'(1) << idx_next) | blank;
  end
`else
  // Enable for the next digit: exactly one bit low.
  always_comb begin
    an_next = ~(NUM_DIGITS'(1) << idx_next);
  end
`endif

  // Prescaler: free-running 0..REFRESH_DIV-1 counter that produces the tick.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Double buffer: loads between boundaries wait in pending (last one wins);
  // a boundary commits pending into active.
  // NOTE: the digit buffers are plain registers, not a memory array, so they
  // are reset along with the rest of the state; a pending load is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      active <= active_next;
      if (boundary) begin
        pending_valid <= 1'b0;
      end else if (load) begin
        pending       <= digits_in;
        pending_valid <= 1'b1;
      end
    end
  end

  // Scan outputs: index, enable and nibble all move together on the tick edge
  // and hold between ticks; frame_done pulses on the boundary edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= IDX_LAST;
      an         <= '1;
      inled_out  <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (tick) begin
        idx       <= idx_next;
        an        <= an_next;
        inled_out <= active_next[4*idx_next +: 4];
      end
    end
  end

endmodule

// File: tb/tb_led7seg_scan.sv
// tb_led7seg_scan: directed bench for led7seg_scan with NUM_DIGITS=4 and
// REFRESH_DIV=4 (default build, leading-zero blanking off). Expected values are
// hand-computed edge by edge: the prescaler starts at 0, so the first tick is
// the 4th edge after reset release and every 4th edge after that.

module tb_led7seg_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  logic            clk;
  logic            rst_n;
  logic            load;
  logic [4*ND-1:0] digits_in;
  logic [3:0]      inled_out;
  logic [ND-1:0]   an;
  logic            frame_done;

  int checks   = 0;
  int failures = 0;

  led7seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .inled_out  (inled_out),
    .an         (an),
    .frame_done (frame_done)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [ND-1:0] an_e,
                           input logic [3:0] led_e, input logic fd_e);
    check({tag, ".an"},         32'(an),         32'(an_e));
    check({tag, ".inled_out"},  32'(inled_out),  32'(led_e));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(fd_e));
  endtask

  // Advance n rising edges, then settle 1 unit past the last one.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = '0;

    // Reset state while held.
    #12;
    check_out("reset_hold", 4'b1111, 4'h0, 1'b0);

    // Release just after an edge; load 1234 so it is sampled on edge 1.
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    load      = 1'b1;
    digits_in = 16'h1234;
    adv(1);                                   // edge 1: pending <= 1234
    load      = 1'b0;
    check_out("pre_tick_e1", 4'b1111, 4'h0, 1'b0);
    adv(2);                                   // edge 3
    check_out("pre_tick_e3", 4'b1111, 4'h0, 1'b0);
    adv(1);                                   // edge 4: first boundary
    check_out("first_frame", 4'b1110, 4'h4, 1'b1);
    adv(1);                                   // edge 5
    check_out("hold_e5", 4'b1110, 4'h4, 1'b0);

    // Scan order.
    adv(3);                                   // edge 8
    check_out("scan_d1", 4'b1101, 4'h3, 1'b0);
    adv(2);                                   // edge 10: between ticks
    check_out("scan_hold", 4'b1101, 4'h3, 1'b0);
    adv(2);                                   // edge 12
    check_out("scan_d2", 4'b1011, 4'h2, 1'b0);
    adv(4);                                   // edge 16
    check_out("scan_d3", 4'b0111, 4'h1, 1'b0);
    adv(4);                                   // edge 20: boundary
    check_out("scan_wrap", 4'b1110, 4'h4, 1'b1);
    adv(1);                                   // edge 21
    check_out("wrap_pulse_end", 4'b1110, 4'h4, 1'b0);

    // Tear-free update: load 5678 while idx=1.
    adv(3);                                   // edge 24: idx=1
    check_out("tf_idx1", 4'b1101, 4'h3, 1'b0);
    load      = 1'b1;
    digits_in = 16'h5678;
    adv(1);                                   // edge 25: pending <= 5678
    load      = 1'b0;
    adv(3);                                   // edge 28
    check_out("tf_old_d2", 4'b1011, 4'h2, 1'b0);
    adv(4);                                   // edge 32
    check_out("tf_old_d3", 4'b0111, 4'h1, 1'b0);
    adv(4);                                   // edge 36: commit
    check_out("tf_new_d0", 4'b1110, 4'h8, 1'b1);
    adv(4);                                   // edge 40
    check_out("tf_new_d1", 4'b1101, 4'h7, 1'b0);
    adv(4);                                   // edge 44
    check_out("tf_new_d2", 4'b1011, 4'h6, 1'b0);
    adv(4);                                   // edge 48
    check_out("tf_new_d3", 4'b0111, 4'h5, 1'b0);

    // Two loads in one frame: last one wins.
    adv(4);                                   // edge 52: boundary, no pending
    check_out("ll_boundary", 4'b1110, 4'h8, 1'b1);
    load      = 1'b1;
    digits_in = 16'hAAAA;
    adv(1);                                   // edge 53
    digits_in = 16'h0007;
    adv(1);                                   // edge 54
    load      = 1'b0;
    adv(2);                                   // edge 56: still old value
    check_out("ll_old_d1", 4'b1101, 4'h7, 1'b0);
    adv(12);                                  // edge 68: commit 0007
    check_out("ll_new_d0", 4'b1110, 4'h7, 1'b1);
    adv(4);                                   // edge 72
    check_out("ll_new_d1", 4'b1101, 4'h0, 1'b0);

    // Load coinciding with the boundary edge (edge 84).
    adv(11);                                  // edge 83
    load      = 1'b1;
    digits_in = 16'h9999;
    adv(1);                                   // edge 84
    load      = 1'b0;
    check_out("sim_d0", 4'b1110, 4'h9, 1'b1);
    adv(4);                                   // edge 88
    check_out("sim_d1", 4'b1101, 4'h9, 1'b0);
    adv(8);                                   // edge 96
    check_out("sim_d3", 4'b0111, 4'h9, 1'b0);

    // Async reset mid-scan with a load pending at idx=2.
    adv(8);                                   // edge 104: idx=1
    check_out("ar_idx1", 4'b1101, 4'h9, 1'b0);
    load      = 1'b1;
    digits_in = 16'h4321;
    adv(1);                                   // edge 105: pending <= 4321
    load      = 1'b0;
    adv(3);                                   // edge 108: idx=2
    check_out("ar_idx2", 4'b1011, 4'h9, 1'b0);
    #3;
    rst_n = 1'b0;                             // between edges
    #1;
    check_out("ar_async", 4'b1111, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    adv(3);
    check_out("ar_pre_tick", 4'b1111, 4'h0, 1'b0);
    adv(1);                                   // first boundary after release
    check_out("ar_first_d0", 4'b1110, 4'h0, 1'b1);
    adv(4);
    check_out("ar_first_d1", 4'b1101, 4'h0, 1'b0);
    adv(4);
    check_out("ar_first_d2", 4'b1011, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
